// File: rtl/vm1_bus_pkg.sv
// Shared definitions for the 1801VM1 bus-ownership controller: arbiter state
// encoding, timer width and default timeout budgets.
package vm1_bus_pkg;

  localparam int unsigned TimerWidth          = 8;
  localparam int unsigned BusTimeoutDefault   = 63;
  localparam int unsigned OfferTimeoutDefault = 15;

  typedef enum logic [2:0] {
    StIdle,
    StCpu,
    StErr,
    StOffer,
    StDma
  } arb_state_e;

endpackage

// File: rtl/bus_timer.sv
// 8-bit loadable down-counter shared by the CPU-cycle and DMA-offer timeouts.
// Saturates at zero; advances only on clock-enabled cycles.
module bus_timer
  import vm1_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  load,
  input  logic [TimerWidth-1:0] value,
  input  logic                  en,
  output logic                  zero
);

  logic [TimerWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TimerWidth'(1);
    end
  end

  // Reflects the post-step count, so expiry is seen in the cycle that uses up the budget.
  assign zero = (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (ce) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Bus-ownership controller: shares the system bus between the CPU and one DMA
// master (DMR/DMGO/SACK) and flags CPU bus cycles that never see RPLY.
module bus_arbiter
  import vm1_bus_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT   = BusTimeoutDefault,
  parameter int unsigned OFFER_TIMEOUT = OfferTimeoutDefault,
  parameter bit          CPU_FAIR      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic cpu_req,
  output logic cpu_gnt,
  input  logic sync,
  input  logic rply,
  output logic berror,
  input  logic dmr,
  output logic dmgo,
  input  logic sack,
  output logic bsy,
  output logic dma_active
);

  arb_state_e state_q, state_d;
  logic debt_q, debt_d;
  logic berror_q, berror_d;
  logic cpu_gnt_q, dmgo_q, bsy_q, dma_active_q;

  logic                  tmr_load;
  logic                  tmr_en;
  logic [TimerWidth-1:0] tmr_value;
  logic                  tmr_zero;

  bus_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .load  (tmr_load),
    .value (tmr_value),
    .en    (tmr_en),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    debt_d    = debt_q;
    berror_d  = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_value = TimerWidth'(BUS_TIMEOUT);

    case (state_q)
      StIdle: begin
        // A master still holding SACK (e.g. across a reset) keeps the bus closed.
        if (!sack) begin
          if (dmr && !(debt_q && cpu_req)) begin
            state_d   = StOffer;
            tmr_load  = 1'b1;
            tmr_value = TimerWidth'(OFFER_TIMEOUT);
          end else if (cpu_req) begin
            state_d  = StCpu;
            tmr_load = 1'b1;
          end
        end
      end
      StCpu: begin
        tmr_en = sync && !rply;
        if (!cpu_req && !sync) begin
          state_d = StIdle;
          debt_d  = 1'b0;
        end else if (tmr_en && tmr_zero) begin
          state_d  = StErr;
          berror_d = 1'b1;
        end
      end
      StErr: begin
        // The CPU did get its cycle, so the debt is paid here as well.
        if (!sync && !cpu_req) begin
          state_d = StIdle;
          debt_d  = 1'b0;
        end
      end
      StOffer: begin
        tmr_en = 1'b1;
        if (sack) begin
          state_d = StDma;
        end else if (!dmr || tmr_zero) begin
          state_d = StIdle;
        end
      end
      StDma: begin
        if (!sack) begin
          state_d = StIdle;
          if (CPU_FAIR) begin
            debt_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      debt_q       <= 1'b0;
      berror_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dmgo_q       <= 1'b0;
      bsy_q        <= 1'b0;
      dma_active_q <= 1'b0;
    end else if (ce) begin
      state_q      <= state_d;
      debt_q       <= debt_d;
      berror_q     <= berror_d;
      cpu_gnt_q    <= (state_d == StCpu) || (state_d == StErr);
      dmgo_q       <= (state_d == StOffer);
      bsy_q        <= (state_d == StCpu) || (state_d == StErr) || (state_d == StDma);
      dma_active_q <= (state_d == StDma);
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign berror     = berror_q;
  assign dmgo       = dmgo_q;
  assign bsy        = bsy_q;
  assign dma_active = dma_active_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset, ce, cpu_req, sync, rply, dmr, sack;
  logic cpu_gnt, berror, dmgo, bsy, dma_active;

  always #5 clk = ~clk;

  bus_arbiter #(
    .BUS_TIMEOUT   (63),
    .OFFER_TIMEOUT (15),
    .CPU_FAIR      (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .cpu_req    (cpu_req),
    .cpu_gnt    (cpu_gnt),
    .sync       (sync),
    .rply       (rply),
    .berror     (berror),
    .dmr        (dmr),
    .dmgo       (dmgo),
    .sack       (sack),
    .bsy        (bsy),
    .dma_active (dma_active)
  );

  // Output vector: {cpu_gnt, berror, dmgo, bsy, dma_active}
  localparam logic [4:0] OIdle  = 5'b00000;
  localparam logic [4:0] OCpu   = 5'b10010;
  localparam logic [4:0] OErrP  = 5'b11010;
  localparam logic [4:0] OOffer = 5'b00100;
  localparam logic [4:0] ODma   = 5'b00011;

  typedef struct {
    int         cyc;
    logic [4:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic [4:0] got;
      e   = exp_q.pop_front();
      got = {cpu_gnt, berror, dmgo, bsy, dma_active};
      n_cmp++;
      if (e.cyc != cyc || got !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b (cycle %0d, due %0d)", e.name, got, e.v, cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [4:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.v    = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [4:0] v);
    step();
    expect_now(name, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ce = 1'b1; cpu_req = 1'b0; sync = 1'b0; rply = 1'b0;
    dmr = 1'b0; sack = 1'b0;
    step();
    chk("reset", OIdle);
    reset = 1'b0;
    chk("idle", OIdle);

    // CPU read with RPLY after five SYNC cycles
    cpu_req = 1'b1;
    chk("cpu_gnt", OCpu);
    chk("cpu_pre_sync", OCpu);
    sync = 1'b1;
    for (int i = 0; i < 5; i++) chk("cpu_wait", OCpu);
    rply = 1'b1;
    chk("cpu_rply", OCpu);
    cpu_req = 1'b0; sync = 1'b0; rply = 1'b0;
    chk("cpu_done", OIdle);

    // Bus timeout, berror held across ce=0, late rply ignored
    cpu_req = 1'b1;
    chk("to_gnt", OCpu);
    sync = 1'b1;
    for (int i = 1; i <= 63; i++) chk((i == 63) ? "to_berror" : "to_wait", (i == 63) ? OErrP : OCpu);
    ce = 1'b0;
    chk("berr_hold1", OErrP);
    chk("berr_hold2", OErrP);
    ce = 1'b1;
    chk("berr_one", OCpu);
    rply = 1'b1;
    chk("late_rply", OCpu);
    rply = 1'b0; sync = 1'b0; cpu_req = 1'b0;
    chk("err_exit", OIdle);

    // DMA handshake
    dmr = 1'b1;
    chk("dma_offer", OOffer);
    chk("dma_offer2", OOffer);
    chk("dma_offer3", OOffer);
    sack = 1'b1;
    chk("dma_take", ODma);
    dmr = 1'b0;
    chk("dma_hold", ODma);
    sack = 1'b0;
    chk("dma_release", OIdle);

    // Offer withdrawn after 15 cycles without sack
    dmr = 1'b1;
    for (int i = 1; i <= 15; i++) chk("offer_wait", OOffer);
    chk("offer_wd", OIdle);
    dmr = 1'b0;
    chk("offer_idle", OIdle);

    // Fairness: DMA and CPU alternate
    reset = 1'b1;
    chk("rst_fair", OIdle);
    reset = 1'b0;
    dmr = 1'b1; cpu_req = 1'b1;
    chk("fair_dma1", OOffer);
    sack = 1'b1;
    chk("fair_dma1_take", ODma);
    sack = 1'b0;
    chk("fair_dma1_end", OIdle);
    chk("fair_cpu1", OCpu);
    cpu_req = 1'b0;
    chk("fair_cpu1_end", OIdle);
    cpu_req = 1'b1;
    chk("fair_dma2", OOffer);
    sack = 1'b1;
    chk("fair_dma2_take", ODma);
    sack = 1'b0;
    chk("fair_dma2_end", OIdle);
    chk("fair_cpu2", OCpu);
    cpu_req = 1'b0; dmr = 1'b0;
    chk("fair_end", OIdle);

    // Reset mid-DMA with sack held, then ce gating
    dmr = 1'b1;
    chk("rd_offer", OOffer);
    sack = 1'b1;
    chk("rd_dma", ODma);
    reset = 1'b1;
    chk("rst_dma", OIdle);
    reset = 1'b0; cpu_req = 1'b1;
    chk("sack_hold1", OIdle);
    chk("sack_hold2", OIdle);
    sack = 1'b0; dmr = 1'b0;
    chk("after_sack", OCpu);
    cpu_req = 1'b0; ce = 1'b0;
    chk("ce_hold1", OCpu);
    chk("ce_hold2", OCpu);
    ce = 1'b1;
    chk("ce_adv", OIdle);
    cpu_req = 1'b1; ce = 1'b0;
    chk("ce_hold3", OIdle);
    ce = 1'b1;
    chk("ce_adv2", OCpu);
    cpu_req = 1'b0;
    chk("final", OIdle);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Synchronous bus-ownership controller for the 1801VM1 soft CPU. It sits beside the bus I/O unit and the CPU control unit. It shares the system bus between the CPU and one external DMA master using the DMR/DMGO/SACK handshake, and it watches every CPU bus cycle for a missing RPLY. It grants the bus to one master at a time, withdraws unanswered DMA offers, and reports CPU bus timeouts as a one-cycle error pulse back to the control unit.

## Interface
Parameters:
- BUS_TIMEOUT, 63 — `ce`-cycles a CPU cycle may wait for RPLY before the error fires (1..255).
- OFFER_TIMEOUT, 15 — `ce`-cycles DMGO stays asserted without SACK before the offer is withdrawn (1..255).
- CPU_FAIR, 1 — when 1, the CPU must get one granted cycle between two DMA tenures whenever `cpu_req` is pending.

Ports:
- clk  in  1  system clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high reset. It takes effect on the clock edge regardless of `ce`.
- ce  in  1  clock enable; all state advances only when `ce`=1.
- cpu_req  in  1  CPU has a bus cycle pending (DATI or DATO).
- cpu_gnt  out  1  CPU may start or continue its bus cycle.
- sync  in  1  SYNC as currently driven by the bus I/O unit.
- rply  in  1  slave reply.
- berror  out  1  one-cycle bus-timeout pulse to the control unit.
- dmr  in  1  DMA request.
- dmgo  out  1  DMA grant offer.
- sack  in  1  DMA master has taken the bus.
- bsy  out  1  bus owned by some master (CPU cycle or DMA tenure).
- dma_active  out  1  DMA master owns the bus.

All outputs are registered. All outputs are 0 during and after reset.

## Operation
States: IDLE, CPU, ERR, OFFER, DMA.

- **IDLE**
  - If `dmr`=1 and the fairness rule permits, go to OFFER and set `dmgo`=1. DMA has priority over the CPU.
  - Otherwise, if `cpu_req`=1, go to CPU and set `cpu_gnt`=1.
- **CPU**
  - `cpu_gnt`=1 and `bsy`=1.
  - The timer loads BUS_TIMEOUT on entry.
  - The timer decrements each `ce`-cycle while `sync`=1 and `rply`=0.
  - When `cpu_req`=0 and `sync`=0, the cycle is complete: clear the fairness debt and return to IDLE.
  - If the timer reaches 0 with `rply` still 0: pulse `berror` for exactly one `ce`-cycle and go to ERR.
  - A DMA request that arrives mid-cycle waits; a CPU cycle is never preempted.
- **ERR**
  - `cpu_gnt` remains 1 so the control unit can drop `sync`.
  - When `sync`=0 and `cpu_req`=0, return to IDLE. A late `rply` here is ignored.
- **OFFER**
  - `dmgo`=1. The timer loads OFFER_TIMEOUT on entry.
  - If `sack`=1: go to DMA and drop `dmgo` on the same edge.
  - If `dmr` drops before `sack`: drop `dmgo` and return to IDLE.
  - If the timer expires: drop `dmgo` and return to IDLE. `berror` is not asserted.
- **DMA**
  - `dma_active`=1, `bsy`=1.
  - When `sack`=0, return to IDLE. If CPU_FAIR=1, set the fairness debt.
  - No timeout applies in this state.
- **Fairness debt**
  - While the debt is set and `cpu_req`=1, IDLE grants the CPU even if `dmr`=1.
  - While the debt is set and `cpu_req`=0, DMA may be offered.
- **Simultaneous events**
  - `rply` and timer expiry in the same cycle: `rply` wins and no error is raised.
  - `sack` and offer expiry in the same cycle: `sack` wins.
- **Reset mid-operation:** return to IDLE, deassert all outputs, clear the timer and the fairness debt. A DMA master still holding `sack` is honored: the first transition out of IDLE waits until `sack`=0.

## Timing
- Decision latency: 1 `ce`-cycle from an input change to the registered output change. Example: `cpu_req` rises in cycle N and `cpu_gnt` is 1 in cycle N+1.
- The error fires after exactly BUS_TIMEOUT `ce`-cycles of `sync`=1 with `rply`=0. The count starts from the first `ce`-cycle with `sync` high.
- Offer withdrawal happens after exactly OFFER_TIMEOUT `ce`-cycles without `sack`.
- The timer is an 8-bit down-counter and saturates at 0.
- When `ce`=0, the state, timer and outputs hold. `berror` stays high across `ce`=0 gaps until the next `ce`-cycle.

## Structure
- Shared package `vm1_bus_pkg`: state encoding (IDLE, CPU, ERR, OFFER, DMA) and default values for BUS_TIMEOUT and OFFER_TIMEOUT.
- Sub-module `bus_timer`: 8-bit loadable down-counter with `load`, `value`, `en`, `ce` inputs and a `zero` output. It is instanced once and shared between the CPU and OFFER states.
- The state machine and fairness flag live in `bus_arbiter`.

## Test plan
- **CPU read:** `cpu_req`=1; `sync`=1 two cycles later; `rply` after 5 cycles; then `cpu_req` and `sync` drop → `cpu_gnt` high throughout, `berror`=0, back to IDLE.
- **Bus timeout:** BUS_TIMEOUT=63, `sync` held with no `rply` → single-cycle `berror` on `ce`-cycle 63; `cpu_gnt` stays 1 until `sync` drops; a late `rply` causes no change.
- **DMA handshake:** `dmr`=1 in IDLE → `dmgo` next cycle; `sack` after 3 cycles → `dmgo`=0, `dma_active`=1; `sack` drops → IDLE.
- **Offer timeout:** `dmr`=1 with `sack` never asserted, OFFER_TIMEOUT=15 → `dmgo` falls after 15 cycles, `berror`=0.
- **Fairness:** `dmr` and `cpu_req` both held, CPU_FAIR=1 → grants alternate DMA, CPU, DMA, … and the CPU is never starved.
- **Reset mid-DMA and `ce` gating:** reset asserted while in the DMA state with `sack` held → all outputs 0 next edge, no new grant until `sack`=0. Then `ce` toggled 1-0-1 → state advances only on `ce`=1 edges.
